// File: rtl/bitonic_pkg.sv
// Shared constants, state encoding and stage tables for the 8-element bitonic sorter.
package bitonic_pkg;

  localparam int N      = 8;
  localparam int DW     = 8;
  localparam int STAGES = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SORT = 2'd2,
    OUT  = 2'd3
  } state_e;

  // Indexed by the stage counter; entries 6 and 7 are never used while sorting.
  localparam logic [3:0] K_TAB [8] = '{4'd2, 4'd4, 4'd4, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8};
  localparam logic [2:0] J_TAB [8] = '{3'd1, 3'd2, 3'd1, 3'd4, 3'd2, 3'd1, 3'd1, 3'd1};

  // Lower index of the lane-th pair: the lane number with a 0 inserted at bit log2(j).
  function automatic logic [2:0] pair_lo(input logic [1:0] lane, input logic [2:0] j);
    logic [2:0] lo;
    case (j)
      3'd1:    lo = {lane, 1'b0};
      3'd2:    lo = {lane[1], 1'b0, lane[0]};
      3'd4:    lo = {1'b0, lane};
      default: lo = {lane, 1'b0};
    endcase
    return lo;
  endfunction

endpackage

// File: rtl/bitonic_sorter8_if.sv
// Load and drain handshakes of the bitonic sorter.
// Both channels are valid/ready: a beat transfers on a rising edge where valid and ready are both high;
// the sender holds valid and data stable until that edge.
interface bitonic_sorter8_if;
  logic                     in_valid;
  logic [bitonic_pkg::DW-1:0] in_data;
  logic                     in_ready;
  logic                     out_valid;
  logic [bitonic_pkg::DW-1:0] out_data;
  logic                     out_ready;
  logic                     busy;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/BITONIC_AS.sv
// Ascending compare-and-swap: out1 is the smaller byte, out2 the larger; equal inputs pass straight through.
module BITONIC_AS
  import bitonic_pkg::*;
(
  input  logic [DW-1:0] in1,
  input  logic [DW-1:0] in2,
  output logic [DW-1:0] out1,
  output logic [DW-1:0] out2
);

  logic swap;

  assign swap = (in1 > in2);
  assign out1 = swap ? in2 : in1;
  assign out2 = swap ? in1 : in2;

endmodule

// File: rtl/bitonic_sorter8.sv
// Sequential 8-byte bitonic sorter: serial load, six network stages on four shared lanes, serial drain.
module bitonic_sorter8
  import bitonic_pkg::*;
#(
  parameter bit OUT_DESC = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  bitonic_sorter8_if.slave  bus,
  output state_e            dbg_state_o
);

  state_e          state_q, state_d;
  logic [DW-1:0]   r_q [N];
  logic [DW-1:0]   r_d [N];
  logic [2:0]      li_q, li_d;
  logic [2:0]      sc_q, sc_d;
  logic [2:0]      oi_q, oi_d;

  logic            in_fire;
  logic            out_fire;
  logic [2:0]      rd_idx;

  logic [3:0]      k_cur;
  logic [2:0]      j_cur;
  logic [2:0]      lo_idx [4];
  logic [2:0]      hi_idx [4];
  logic            asc    [4];
  logic [DW-1:0]   l_in1  [4];
  logic [DW-1:0]   l_in2  [4];
  logic [DW-1:0]   l_out1 [4];
  logic [DW-1:0]   l_out2 [4];

  assign bus.in_ready  = (state_q == IDLE) || (state_q == LOAD);
  assign bus.out_valid = (state_q == OUT);
  assign bus.busy      = (state_q == SORT) || (state_q == OUT);
  assign in_fire       = bus.in_valid && bus.in_ready;
  assign out_fire      = bus.out_valid && bus.out_ready;
  // For a 3-bit index, 7 - oi is simply the bitwise complement.
  assign rd_idx        = OUT_DESC ? ~oi_q : oi_q;
  assign bus.out_data  = (state_q == OUT) ? r_q[rd_idx] : '0;
  assign dbg_state_o   = state_q;

  always_comb begin
    k_cur = K_TAB[sc_q];
    j_cur = J_TAB[sc_q];
    for (int l = 0; l < 4; l++) begin
      lo_idx[l] = pair_lo(2'(l), j_cur);
      hi_idx[l] = lo_idx[l] | j_cur;
      asc[l]    = (({1'b0, lo_idx[l]} & k_cur) == 4'd0);
      l_in1[l]  = r_q[lo_idx[l]];
      l_in2[l]  = r_q[hi_idx[l]];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    BITONIC_AS u_as (
      .in1  (l_in1[g]),
      .in2  (l_in2[g]),
      .out1 (l_out1[g]),
      .out2 (l_out2[g])
    );
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    li_d    = li_q;
    sc_d    = sc_q;
    oi_d    = oi_q;
    case (state_q)
      IDLE: begin
        if (in_fire) begin
          r_d[0]  = bus.in_data;
          li_d    = 3'd1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (in_fire) begin
          r_d[li_q] = bus.in_data;
          li_d      = li_q + 3'd1;
          if (li_q == 3'd7) begin
            sc_d    = 3'd0;
            state_d = SORT;
          end
        end
      end
      SORT: begin
        // Pairs are disjoint, so all four lane results land on the same edge without conflict.
        for (int l = 0; l < 4; l++) begin
          if (asc[l]) begin
            r_d[lo_idx[l]] = l_out1[l];
            r_d[hi_idx[l]] = l_out2[l];
          end else begin
            r_d[lo_idx[l]] = l_out2[l];
            r_d[hi_idx[l]] = l_out1[l];
          end
        end
        sc_d = sc_q + 3'd1;
        if (sc_q == 3'(STAGES - 1)) begin
          sc_d    = 3'd0;
          oi_d    = 3'd0;
          state_d = OUT;
        end
      end
      OUT: begin
        if (out_fire) begin
          oi_d = oi_q + 3'd1;
          if (oi_q == 3'd7) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      li_q    <= '0;
      sc_q    <= '0;
      oi_q    <= '0;
      for (int i = 0; i < N; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      li_q    <= li_d;
      sc_q    <= sc_d;
      oi_q    <= oi_d;
      for (int i = 0; i < N; i++) begin
        r_q[i] <= r_d[i];
      end
    end
  end

endmodule

// File: tb/tb_bitonic_sorter8.sv
// Directed bench for bitonic_sorter8: ascending and descending instances driven in lockstep.
module tb_bitonic_sorter8;
  import bitonic_pkg::*;

  typedef struct {
    logic [7:0] din [8];
    logic [7:0] srt [8];
  } vec_t;

  logic   clk;
  logic   rst_n;
  state_e dbg_a, dbg_d;
  int     tests;
  int     fails;
  vec_t   vt [6];
  logic [7:0] exp_a [$];
  logic [7:0] exp_d [$];

  bitonic_sorter8_if ifa ();
  bitonic_sorter8_if ifd ();

  bitonic_sorter8 #(.OUT_DESC(1'b0)) u_asc (.clk(clk), .rst_n(rst_n), .bus(ifa.slave), .dbg_state_o(dbg_a));
  bitonic_sorter8 #(.OUT_DESC(1'b1)) u_dsc (.clk(clk), .rst_n(rst_n), .bus(ifd.slave), .dbg_state_o(dbg_d));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_vec(input int idx, input logic [63:0] din, input logic [63:0] srt);
    for (int b = 0; b < 8; b++) begin
      vt[idx].din[b] = din[63 - 8*b -: 8];
      vt[idx].srt[b] = srt[63 - 8*b -: 8];
    end
  endtask

  // driver tasks
  task automatic drive_in(input logic v, input logic [7:0] d);
    ifa.in_valid = v;
    ifd.in_valid = v;
    ifa.in_data  = d;
    ifd.in_data  = d;
  endtask

  task automatic drive_junk(input int c, input bit junk);
    if (junk) begin
      drive_in(c[0], 8'hFF);
      check("in_ready_low_while_busy", {31'b0, ifa.in_ready}, 32'd0);
    end else begin
      drive_in(1'b0, 8'h00);
    end
  endtask

  // Entered at a falling edge; leaves at the falling edge of cycle T+1 with in_valid low.
  task automatic send_frame(input int v, input bit bub);
    int n;
    for (int b = 0; b < 8; b++) begin
      if (bub && b > 0) begin
        drive_in(1'b0, 8'h00);
        repeat (2) @(negedge clk);
      end
      drive_in(1'b1, vt[v].din[b]);
      n = 0;
      while (!ifa.in_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) check("in_ready_wait", 32'd0, 32'd1);
      @(negedge clk);
    end
    drive_in(1'b0, 8'h00);
  endtask

  task automatic wait_out(input bit junk);
    int lat;
    lat = 1;
    check("busy_first_sort", {31'b0, ifa.busy}, 32'd1);
    check("in_ready_first_sort", {31'b0, ifa.in_ready}, 32'd0);
    while (!ifa.out_valid && lat < 50) begin
      drive_junk(lat, junk);
      @(negedge clk);
      lat++;
    end
    check("out_valid_latency", lat, 32'd7);
    check("out_valid_desc", {31'b0, ifd.out_valid}, 32'd1);
  endtask

  task automatic collect(input int stall, input bit junk);
    int got;
    int c;
    logic [7:0] ea, ed;
    got = 0;
    c = 0;
    while (got < 8 && c < 200) begin
      ifa.out_ready = (c >= stall);
      ifd.out_ready = (c >= stall);
      drive_junk(c, junk);
      if (c < stall) begin
        check("hold_valid", {31'b0, ifa.out_valid}, 32'd1);
        check("hold_data_asc", {24'b0, ifa.out_data}, {24'b0, exp_a[0]});
        check("hold_data_desc", {24'b0, ifd.out_data}, {24'b0, exp_d[0]});
      end else if (ifa.out_valid) begin
        ea = exp_a.pop_front();
        ed = exp_d.pop_front();
        check("out_data_asc", {24'b0, ifa.out_data}, {24'b0, ea});
        check("out_data_desc", {24'b0, ifd.out_data}, {24'b0, ed});
        got++;
      end
      @(negedge clk);
      c++;
    end
    drive_in(1'b0, 8'h00);
    ifa.out_ready = 1'b1;
    ifd.out_ready = 1'b1;
    check("out_beats", got, 32'd8);
    check("out_cycles", c, 32'(8 + stall));
    check("in_ready_after_frame", {31'b0, ifa.in_ready}, 32'd1);
    check("out_valid_after_frame", {31'b0, ifa.out_valid}, 32'd0);
    check("busy_after_frame", {31'b0, ifd.busy}, 32'd0);
  endtask

  // scoreboard fill + one full frame
  task automatic run_frame(input int v, input bit bub, input int stall, input bit junk);
    exp_a.delete();
    exp_d.delete();
    for (int b = 0; b < 8; b++) begin
      exp_a.push_back(vt[v].srt[b]);
      exp_d.push_back(vt[v].srt[7 - b]);
    end
    send_frame(v, bub);
    wait_out(junk);
    collect(stall, junk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, {31'b0, ifa.in_ready}, 32'd1);
    check({tag, "_out_valid"}, {31'b0, ifa.out_valid}, 32'd0);
    check({tag, "_out_data"}, {24'b0, ifa.out_data}, 32'd0);
    check({tag, "_busy"}, {31'b0, ifa.busy}, 32'd0);
    check({tag, "_state"}, {30'b0, dbg_a}, {30'b0, IDLE});
    check({tag, "_out_valid_desc"}, {31'b0, ifd.out_valid}, 32'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    set_vec(0, 64'h07060504_03020100, 64'h00010203_04050607);
    set_vec(1, 64'hC803C800_FF110380, 64'h00030311_80C8C8FF);
    set_vec(2, 64'h01020304_05060708, 64'h01020304_05060708);
    set_vec(3, 64'h08070605_04030201, 64'h01020304_05060708);
    set_vec(4, 64'h55555555_55555555, 64'h55555555_55555555);
    set_vec(5, 64'h10F010F0_8001FE7F, 64'h0110107F_80F0F0FE);

    rst_n = 1'b0;
    drive_in(1'b0, 8'h00);
    ifa.out_ready = 1'b1;
    ifd.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("after_reset");

    // table: back-to-back frames, vectors 2 and 3 are consecutive
    for (int v = 0; v < 6; v++) begin
      if (v != 4) run_frame(v, 1'b0, 0, 1'b0);
    end

    // bubbles on load, stall at first output
    run_frame(1, 1'b1, 5, 1'b0);

    // garbage in_valid pulses during SORT/OUT
    run_frame(5, 1'b0, 0, 1'b1);

    // reset in the third SORT cycle
    send_frame(0, 1'b0);
    repeat (2) @(negedge clk);
    check("pre_reset_state", {30'b0, dbg_a}, {30'b0, SORT});
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_reset");
    @(negedge clk);
    check_reset_values("held_reset");
    rst_n = 1'b1;
    run_frame(4, 1'b0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
